// File: rtl/multicycle_rv_core.sv
// multicycle_rv_core: multi-cycle RV32I-subset core with valid/req fetch and data ports.
// Define CPU_PERF_CNT_EN to build the retired-instruction counter (instret); otherwise instret reads 0.
module multicycle_rv_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NUM_REGS = 32
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pcAddr,
  output logic        insReq,
  input  logic        insValid,
  input  logic [31:0] insData,
  output logic        memReq,
  output logic        memWe,
  output logic [31:0] memAddr,
  output logic [31:0] memWData,
  input  logic        memValid,
  input  logic [31:0] memRData,
  output logic        halted,
  output logic [31:0] instret
);
  localparam int AW = $clog2(NUM_REGS);
  typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} state_t;
  state_t state, state_n;
  logic [31:0] pc, pc_n, ir, ir_n, addr_n, wdata_n;
  logic        mwe_n, wb_en;
  logic [31:0] wb_data;
  logic [31:0] regs [NUM_REGS];
  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u, rv1, rv2, opb, alu, res, tgt, ea;
  logic        alu_ok, is_r, is_i, is_lui, is_lw, is_sw, is_br, is_jal, is_jalr;
  logic        use_rs1, use_rs2, use_rd, bad_reg, legal, taken;
  assign {f7, rs2, rs1, f3, rd, opc} = ir;
  assign imm_i = {{20{ir[31]}}, ir[31:20]};
  assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
  assign imm_u = {ir[31:12], 12'b0};
  assign rv1 = rs1 == 5'd0 ? 32'd0 : regs[rs1[AW-1:0]];
  assign rv2 = rs2 == 5'd0 ? 32'd0 : regs[rs2[AW-1:0]];
  assign alu_ok  = f3 inside {3'd0, 3'd2, 3'd4, 3'd6, 3'd7};
  assign is_r    = opc == 7'h33 && alu_ok && (f7 == 7'h00 || (f7 == 7'h20 && f3 == 3'd0));
  assign is_i    = opc == 7'h13 && alu_ok;
  assign is_lui  = opc == 7'h37;
  assign is_lw   = opc == 7'h03 && f3 == 3'd2;
  assign is_sw   = opc == 7'h23 && f3 == 3'd2;
  assign is_br   = opc == 7'h63 && f3[2:1] == 2'b00;
  assign is_jal  = opc == 7'h6f;
  assign is_jalr = opc == 7'h67 && f3 == 3'd0;
  assign use_rs1 = is_r | is_i | is_lw | is_sw | is_br | is_jalr;
  assign use_rs2 = is_r | is_sw | is_br;
  assign use_rd  = is_r | is_i | is_lui | is_lw | is_jal | is_jalr;
  // RV32E builds reject any register field naming x16..x31
  assign bad_reg = NUM_REGS < 32 && ((use_rs1 && rs1[4]) || (use_rs2 && rs2[4]) || (use_rd && rd[4]));
  assign legal   = (is_r | is_i | is_lui | is_lw | is_sw | is_br | is_jal | is_jalr) && !bad_reg;
  assign opb = is_r ? rv2 : imm_i;
  assign alu = f3 == 3'd0 ? (is_r && f7[5] ? rv1 - opb : rv1 + opb) :
               f3 == 3'd7 ? rv1 & opb :
               f3 == 3'd6 ? rv1 | opb :
               f3 == 3'd4 ? rv1 ^ opb : {31'b0, $signed(rv1) < $signed(opb)};
  assign taken = (rv1 == rv2) ^ f3[0];
  assign tgt = is_jalr ? (rv1 + imm_i) & ~32'd1 :
               is_jal ? pc + imm_j :
               is_br && taken ? pc + imm_b : pc + 32'd4;
  assign res = is_lui ? imm_u : (is_jal | is_jalr) ? pc + 32'd4 : alu;
  assign ea = rv1 + (is_sw ? imm_s : imm_i);
  assign pcAddr = pc;
  assign halted = state == HALT;
  always_comb begin
    state_n = state;
    pc_n    = pc;
    ir_n    = ir;
    addr_n  = memAddr;
    wdata_n = memWData;
    mwe_n   = memWe;
    wb_en   = 1'b0;
    wb_data = res;
    case (state)
      FETCH: if (insReq && insValid) begin
        ir_n    = insData;
        state_n = EXEC;
      end
      EXEC: if (!legal) state_n = HALT;
      else if (is_lw || is_sw) begin
        if (ea[1:0] != 2'b00) state_n = HALT;
        else begin
          state_n = MEM;
          addr_n  = ea;
          wdata_n = rv2;
          mwe_n   = is_sw;
        end
      end else if (tgt[1:0] != 2'b00) state_n = HALT;
      else begin
        pc_n    = tgt;
        wb_en   = use_rd;
        state_n = FETCH;
      end
      MEM: if (memReq && memValid) begin
        wb_en   = !memWe;
        wb_data = memRData;
        pc_n    = pc + 32'd4;
        state_n = FETCH;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      ir       <= '0;
      insReq   <= 1'b0;
      memReq   <= 1'b0;
      memWe    <= 1'b0;
      memAddr  <= '0;
      memWData <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      ir       <= ir_n;
      insReq   <= state_n == FETCH;
      memReq   <= state_n == MEM;
      memWe    <= mwe_n;
      memAddr  <= addr_n;
      memWData <= wdata_n;
      if (wb_en && rd != 5'd0) regs[rd[AW-1:0]] <= wb_data;
    end
  end
`ifdef CPU_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) instret <= '0;
    else if ((state == EXEC || state == MEM) && state_n == FETCH) instret <= instret + 32'd1;
  end
`else
  assign instret = '0;
`endif
endmodule
